// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle RISC-V core: word RAM plus an
// MMIO block with an output FIFO, a free-running cycle counter and drop count.
module dmem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] OutData,
  output logic        OutValid,
  input  logic        OutReady
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   ram_q  [RAM_WORDS];
  logic [31:0]   fifo_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [7:0]    drops_q, drops_d;

  logic          is_ram, is_mmio;
  logic [1:0]    off;
  logic [AW-1:0] ram_idx;
  logic          ram_we, fifo_we;
  logic          push_req, push, pop;
  logic          full, empty, cyc_wr;
  logic [5:0]    cnt6;

  logic          unused;
  assign unused = ^{Addr[27:AW+2], Addr[1:0]};

  // Address decode and FIFO handshake qualification.
  always_comb begin
    is_ram   = (Addr[31:28] == 4'h0);
    is_mmio  = (Addr[31:28] == 4'hF);
    off      = Addr[3:2];
    ram_idx  = Addr[AW+1:2];
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    pop      = !empty && OutReady;
    push_req = MemWrite && is_mmio && (off == 2'd0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push     = push_req && (!full || pop);
    cyc_wr   = MemWrite && is_mmio && (off == 2'd2);
    ram_we   = MemWrite && is_ram && !reset;
    fifo_we  = push && !reset;
  end

  // Next-state for FIFO pointers, occupancy, counters.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    cycles_d = cycles_q + 32'd1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (push)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
    if (push_req && !push && drops_q != 8'hFF)
      drops_d = drops_q + 8'd1;
    if (cyc_wr)
      cycles_d = WriteData;
  end

  // Control state register; reset wins over any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      drops_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      drops_q  <= drops_d;
    end
  end

  // Storage arrays; never reset.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram_q[ram_idx] <= WriteData;
    if (fifo_we)
      fifo_q[wr_ptr_q] <= WriteData;
  end

  // Zero-latency load path and FIFO head.
  always_comb begin
    cnt6     = 6'(count_q);
    ReadData = '0;
    unique case (1'b1)
      is_ram:  ReadData = ram_q[ram_idx];
      is_mmio: begin
        unique case (off)
          2'd0: ReadData = '0;
          2'd1: ReadData = {24'b0, cnt6, full, empty};
          2'd2: ReadData = cycles_q;
          2'd3: ReadData = {24'b0, drops_q};
        endcase
      end
      default: ReadData = '0;
    endcase
    OutData  = fifo_q[rd_ptr_q];
    OutValid = !empty;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a queue-based reference
// model of RAM, FIFO, cycle counter and drop counter.
module tb_dmem_responder;

  localparam int RW = 64;
  localparam int FD = 4;

  logic        clk = 0;
  logic        reset = 1;
  logic        MemWrite = 0;
  logic [31:0] Addr = 0;
  logic [31:0] WriteData = 0;
  logic [31:0] ReadData;
  logic [31:0] OutData;
  logic        OutValid;
  logic        OutReady = 0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [RW];
  logic [31:0] m_q [$];
  logic [31:0] m_cycles;
  logic [7:0]  m_drops;

  dmem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int sz;
    sz = m_q.size();
    if (a[31:28] == 4'h0) return m_ram[(a >> 2) % RW];
    if (a[31:28] != 4'hF) return 32'h0;
    case (a[3:2])
      2'd1: return 32'(sz * 4 + (sz == FD ? 2 : 0) + (sz == 0 ? 1 : 0));
      2'd2: return m_cycles;
      2'd3: return {24'b0, m_drops};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] a;
    bit do_pop;
    a = Addr;
    if (reset) begin
      m_q.delete();
      m_cycles = 0;
      m_drops = 0;
      return;
    end
    do_pop = (m_q.size() > 0) && OutReady;
    if (do_pop) void'(m_q.pop_front());
    if (MemWrite && a[31:28] == 4'h0)
      m_ram[(a >> 2) % RW] = WriteData;
    if (MemWrite && a[31:28] == 4'hF && a[3:2] == 2'd0) begin
      if (m_q.size() < FD) m_q.push_back(WriteData);
      else if (m_drops != 8'hFF) m_drops = m_drops + 1;
    end
    if (MemWrite && a[31:28] == 4'hF && a[3:2] == 2'd2)
      m_cycles = WriteData;
    else
      m_cycles = m_cycles + 1;
  endtask

  task automatic drive(input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy,
                       input logic rst);
    MemWrite = mw; Addr = a; WriteData = wd;
    OutReady = rdy; reset = rst;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 32'hF000_0000, 32'hAAAA_5555, 0, 1);
    tick();
    drive(0, 32'hF000_0004, 0, 0, 0);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", OutValid);
    end
    checks++;
    if (ReadData !== 32'h1) begin
      errors++; $display("FAIL reset_status got %h exp 1", ReadData);
    end
    drive(0, 32'hF000_0008, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h0) begin
      errors++; $display("FAIL reset_cycles got %h exp 0", ReadData);
    end
  endtask

  task automatic test_ram();
    for (int i = 0; i < RW; i++) begin
      drive(1, 32'(i * 4), $urandom, 0, 0);
      tick();
    end
    drive(1, 32'h10, 32'h1111_1111, 0, 0);
    tick();
    drive(1, 32'h10, 32'hDEAD_BEEF, 0, 0);
    checks++;
    if (ReadData !== 32'h1111_1111) begin
      errors++; $display("FAIL ram_old got %h exp 11111111", ReadData);
    end
    tick();
    drive(0, 32'h10, 0, 0, 0);
    checks++;
    if (ReadData !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_rd got %h exp deadbeef", ReadData);
    end
    drive(0, 32'h113, 0, 0, 0);
    checks++;
    if (ReadData !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_alias got %h exp deadbeef", ReadData);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, {4'h0, 28'($urandom)}, $urandom, 0, 0);
      tick();
      drive(0, {4'h0, 28'($urandom)}, 0, 0, 0);
      checks++;
      if (ReadData !== exp_read(Addr)) begin
        errors++;
        $display("FAIL ram_rand a=%h got %h exp %h",
                 Addr, ReadData, exp_read(Addr));
      end
    end
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 32'hF000_0000, 32'(i), 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      checks++;
      if (OutValid !== 1'b1 || OutData !== 32'h1) begin
        errors++;
        $display("FAIL fill_head v=%b got %h exp 1", OutValid, OutData);
      end
    end
    drive(0, 32'hF000_0004, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h12) begin
      errors++; $display("FAIL fill_status got %h exp 12", ReadData);
    end
    drive(0, 32'hF000_000C, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h1) begin
      errors++; $display("FAIL fill_drops got %h exp 1", ReadData);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 0);
      checks++;
      if (OutValid !== 1'b1 || OutData !== 32'(i)) begin
        errors++;
        $display("FAIL drain v=%b got %h exp %h", OutValid, OutData, i);
      end
      tick();
    end
    drive(0, 32'hF000_0004, 0, 0, 0);
    checks++;
    if (OutValid !== 1'b0 || ReadData !== 32'h1) begin
      errors++;
      $display("FAIL drain_end v=%b got %h exp 1", OutValid, ReadData);
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] exp_ord [4];
    exp_ord = '{32'd2, 32'd3, 32'd4, 32'd9};
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'hF000_0000, 32'(i), 0, 0);
      tick();
    end
    drive(1, 32'hF000_0000, 32'd9, 1, 0);
    tick();
    drive(0, 32'hF000_0004, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h12) begin
      errors++; $display("FAIL ppf_status got %h exp 12", ReadData);
    end
    drive(0, 32'hF000_000C, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h1) begin
      errors++; $display("FAIL ppf_drops got %h exp 1", ReadData);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      checks++;
      if (OutValid !== 1'b1 || OutData !== exp_ord[i]) begin
        errors++;
        $display("FAIL ppf_order v=%b got %h exp %h",
                 OutValid, OutData, exp_ord[i]);
      end
      tick();
    end
  endtask

  task automatic test_cycles();
    logic [31:0] exp_c [3];
    exp_c = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    drive(1, 32'hF000_0008, 32'hFFFF_FFFE, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'hF000_0008, 0, 0, 0);
      checks++;
      if (ReadData !== exp_c[i]) begin
        errors++;
        $display("FAIL cycles got %h exp %h", ReadData, exp_c[i]);
      end
      tick();
    end
  endtask

  task automatic test_drops_reset();
    for (int i = 0; i < FD + 300; i++) begin
      drive(1, 32'hF000_0000, $urandom, 0, 0);
      tick();
    end
    drive(0, 32'hF000_000C, 0, 0, 0);
    checks++;
    if (ReadData !== 32'hFF) begin
      errors++; $display("FAIL drops_sat got %h exp ff", ReadData);
    end
    drive(1, 32'hF000_0000, 32'h77, 1, 1);
    tick();
    drive(0, 32'hF000_0004, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_status got %h v=%b exp 1 v=0", ReadData, OutValid);
    end
    drive(0, 32'hF000_000C, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h0) begin
      errors++; $display("FAIL rst_drops got %h exp 0", ReadData);
    end
    drive(0, 32'hF000_0008, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h0) begin
      errors++; $display("FAIL rst_cycles got %h exp 0", ReadData);
    end
  endtask

  task automatic test_unmapped();
    drive(1, 32'h8000_0000, 32'hCAFE_F00D, 0, 0);
    tick();
    drive(0, 32'h8000_0000, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h0) begin
      errors++; $display("FAIL unm_read got %h exp 0", ReadData);
    end
    drive(0, 32'hF000_0000, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h0) begin
      errors++; $display("FAIL fifo_data_read got %h exp 0", ReadData);
    end
    drive(0, 32'h0, 0, 0, 0);
    checks++;
    if (ReadData !== m_ram[0]) begin
      errors++; $display("FAIL unm_ram got %h exp %h", ReadData, m_ram[0]);
    end
    drive(0, 32'hF000_0004, 0, 0, 0);
    checks++;
    if (ReadData !== 32'h1 || OutValid !== 1'b0) begin
      errors++; $display("FAIL unm_fifo got %h exp 1", ReadData);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: a = {4'h0, 28'($urandom)};
        1, 2: a = {4'hF, 24'($urandom), 4'($urandom_range(0, 15))};
        default: a = {4'h8, 28'($urandom)};
      endcase
      if (a[31:28] == 4'hF && a[3:2] == 2'd2 && $urandom_range(0, 7) != 0)
        a[3:2] = 2'd0;
      drive(1'($urandom), a, $urandom, 1'($urandom), 0);
      checks++;
      if (ReadData !== exp_read(a)) begin
        errors++;
        $display("FAIL rnd_read a=%h got %h exp %h", a, ReadData, exp_read(a));
      end
      checks++;
      if (OutValid !== (m_q.size() > 0)) begin
        errors++;
        $display("FAIL rnd_valid got %b exp %0d", OutValid, m_q.size());
      end
      if (m_q.size() > 0) begin
        checks++;
        if (OutData !== m_q[0]) begin
          errors++;
          $display("FAIL rnd_head got %h exp %h", OutData, m_q[0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    m_q.delete();
    m_cycles = 0;
    m_drops = 0;
    for (int i = 0; i < RW; i++) m_ram[i] = 0;
    test_reset();
    test_ram();
    test_fifo_fill();
    test_push_pop_full();
    test_cycles();
    test_drops_reset();
    test_unmapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
